// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined main control decoder.
// Holds the opcode/ALU_op encodings, the control word and the per-stage register layouts.
package pipe_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_R     = 6'd0;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd9;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd15;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;

    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_R      = 3'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI   = 3'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTIU  = 3'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 3'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI    = 3'd7;

    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         regdst;
        logic               branch;
        logic               bne;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic [1:0]         memtoreg;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [REG_W-1:0] wreg;
    } ex_stage_t;

    typedef struct packed {
        logic             branch;
        logic             bne;
        logic             memread;
        logic             memwrite;
        logic             regwrite;
        logic [1:0]       memtoreg;
        logic [REG_W-1:0] wreg;
    } mem_stage_t;

    typedef struct packed {
        logic             regwrite;
        logic [1:0]       memtoreg;
        logic [REG_W-1:0] wreg;
    } wb_stage_t;

    function automatic ctrl_t make_ctrl(
        input logic               alusrc,
        input logic [ALUOP_W-1:0] aluop,
        input logic [1:0]         regdst,
        input logic               branch,
        input logic               bne,
        input logic               memread,
        input logic               memwrite,
        input logic               regwrite,
        input logic [1:0]         memtoreg
    );
        ctrl_t c;
        c.alusrc   = alusrc;
        c.aluop    = aluop;
        c.regdst   = regdst;
        c.branch   = branch;
        c.bne      = bne;
        c.memread  = memread;
        c.memwrite = memwrite;
        c.regwrite = regwrite;
        c.memtoreg = memtoreg;
        return c;
    endfunction

    function automatic mem_stage_t ex_to_mem(input ex_stage_t s);
        mem_stage_t m;
        m.branch   = s.ctrl.branch;
        m.bne      = s.ctrl.bne;
        m.memread  = s.ctrl.memread;
        m.memwrite = s.ctrl.memwrite;
        m.regwrite = s.ctrl.regwrite;
        m.memtoreg = s.ctrl.memtoreg;
        m.wreg     = s.wreg;
        return m;
    endfunction

    function automatic wb_stage_t mem_to_wb(input mem_stage_t s);
        wb_stage_t w;
        w.regwrite = s.regwrite;
        w.memtoreg = s.memtoreg;
        w.wreg     = s.wreg;
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decoder_if.sv
// Bundle between the IF/ID register, the control decoder and the datapath.
// slave = decoder side, master = CPU/datapath side.
interface pipe_ctrl_decoder_if;
    import pipe_ctrl_pkg::*;

    logic [31:0]        instr_i;
    logic               instr_valid_i;
    logic               flush_i;
    logic               stall_o;
    logic               illegal_o;
    logic               ex_alusrc_o;
    logic [ALUOP_W-1:0] ex_aluop_o;
    logic [1:0]         ex_regdst_o;
    logic [REG_W-1:0]   ex_wreg_o;
    logic               mem_branch_o;
    logic               mem_bne_o;
    logic               mem_memread_o;
    logic               mem_memwrite_o;
    logic [REG_W-1:0]   mem_wreg_o;
    logic               wb_regwrite_o;
    logic [1:0]         wb_memtoreg_o;
    logic [REG_W-1:0]   wb_wreg_o;

    modport slave (
        input  instr_i, instr_valid_i, flush_i,
        output stall_o, illegal_o,
               ex_alusrc_o, ex_aluop_o, ex_regdst_o, ex_wreg_o,
               mem_branch_o, mem_bne_o, mem_memread_o, mem_memwrite_o, mem_wreg_o,
               wb_regwrite_o, wb_memtoreg_o, wb_wreg_o
    );

    modport master (
        output instr_i, instr_valid_i, flush_i,
        input  stall_o, illegal_o,
               ex_alusrc_o, ex_aluop_o, ex_regdst_o, ex_wreg_o,
               mem_branch_o, mem_bne_o, mem_memread_o, mem_memwrite_o, mem_wreg_o,
               wb_regwrite_o, wb_memtoreg_o, wb_wreg_o
    );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode -> control word decoder, shared with the pipelined CPU.
// Unknown opcodes produce a bubble with legal_o low.
module ctrl_decode_comb
    import pipe_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_o,
    output logic            legal_o,
    output logic            use_rt_o
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl_o   = BUBBLE;
        legal_o  = 1'b1;
        use_rt_o = 1'b0;
        case (op_i)
            OP_R: begin
                ctrl_o   = make_ctrl(1'b0, ALUOP_R, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
                use_rt_o = 1'b1;
            end
            OP_ADDI:  ctrl_o = make_ctrl(1'b1, ALUOP_ADDI,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
            OP_SLTIU: ctrl_o = make_ctrl(1'b1, ALUOP_SLTIU, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
            OP_ORI:   ctrl_o = make_ctrl(1'b1, ALUOP_ORI,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
            OP_LUI:   ctrl_o = make_ctrl(1'b1, ALUOP_LUI,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
            OP_BEQ: begin
                ctrl_o   = make_ctrl(1'b0, ALUOP_BRANCH, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
                use_rt_o = 1'b1;
            end
            OP_BNE: begin
                ctrl_o   = make_ctrl(1'b0, ALUOP_BRANCH, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
                use_rt_o = 1'b1;
            end
            OP_LW:    ctrl_o = make_ctrl(1'b1, ALUOP_ADDI, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
            OP_SW: begin
                ctrl_o   = make_ctrl(1'b1, ALUOP_ADDI, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
                use_rt_o = 1'b1;
            end
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// Pipelined main control: decodes in ID, carries control through ID/EX, EX/MEM and MEM/WB,
// and generates the load-use stall and branch-flush bubbles.
module pipe_ctrl_decoder
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned HAZARD_EN = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipe_ctrl_decoder_if.slave  bus
);

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs, rt, rd;
    ctrl_t            dec_ctrl;
    logic             dec_legal, dec_use_rt;
    logic [REG_W-1:0] dec_wreg;
    logic             load_use;

    ex_stage_t  ex_d,  ex_q;
    mem_stage_t mem_d, mem_q;
    wb_stage_t  wb_d,  wb_q;
    logic       illegal_d, illegal_q;

    assign op = bus.instr_i[31:26];
    assign rs = bus.instr_i[25:21];
    assign rt = bus.instr_i[20:16];
    assign rd = bus.instr_i[15:11];

    // Immediate / shamt / funct bits are decoded downstream, not here.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.instr_i[10:0]};

    ctrl_decode_comb u_decode (
        .op_i     (op),
        .ctrl_o   (dec_ctrl),
        .legal_o  (dec_legal),
        .use_rt_o (dec_use_rt)
    );

    // A non-writing instruction carries wreg 0 so it can never match a hazard compare.
    assign dec_wreg = !dec_ctrl.regwrite   ? '0 :
                      (dec_ctrl.regdst == 2'd1) ? rd : rt;

    always_comb begin
        load_use = 1'b0;
        if (HAZARD_EN != 0 && bus.instr_valid_i && !bus.flush_i &&
            ex_q.ctrl.memread && ex_q.wreg != '0) begin
            load_use = (dec_legal && ex_q.wreg == rs) || (dec_use_rt && ex_q.wreg == rt);
        end
    end

    always_comb begin
        ex_d      = '0;
        illegal_d = 1'b0;
        if (!bus.flush_i && bus.instr_valid_i && !load_use) begin
            if (dec_legal) begin
                ex_d.ctrl = dec_ctrl;
                ex_d.wreg = dec_wreg;
            end else begin
                illegal_d = 1'b1;
            end
        end
        mem_d = bus.flush_i ? '0 : ex_to_mem(ex_q);
        wb_d  = mem_to_wb(mem_q);
    end

    // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.stall_o        = load_use;
    assign bus.illegal_o      = illegal_q;
    assign bus.ex_alusrc_o    = ex_q.ctrl.alusrc;
    assign bus.ex_aluop_o     = ex_q.ctrl.aluop;
    assign bus.ex_regdst_o    = ex_q.ctrl.regdst;
    assign bus.ex_wreg_o      = ex_q.wreg;
    assign bus.mem_branch_o   = mem_q.branch;
    assign bus.mem_bne_o      = mem_q.bne;
    assign bus.mem_memread_o  = mem_q.memread;
    assign bus.mem_memwrite_o = mem_q.memwrite;
    assign bus.mem_wreg_o     = mem_q.wreg;
    assign bus.wb_regwrite_o  = wb_q.regwrite;
    assign bus.wb_memtoreg_o  = wb_q.memtoreg;
    assign bus.wb_wreg_o      = wb_q.wreg;

endmodule

// File: doc/pipe_ctrl_decoder.md
Name: pipe_ctrl_decoder

Overview:
Pipelined successor to the single-cycle main control decoder.
- Decodes the 6-bit opcode plus register fields of the instruction in the ID stage.
- Registers the control word into ID/EX, then carries the MEM and WB subsets through EX/MEM and MEM/WB.
- Detects load-use hazards and stalls the front end.
- Handles branch flushes and unknown opcodes, which the single-cycle decoder left undefined.
- Sits between the IF/ID register and the datapath of the 5-stage pipelined CPU.

Parameters:
- OP_W, 6, opcode field width (instr_i[31:26]).
- REG_W, 5, register address width.
- ALUOP_W, 3, ALU_op width toward ALU_Ctrl.
- HAZARD_EN, 1, 1 enables load-use stall detection; 0 ties stall_o low.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_i  in  32  IF/ID instruction: op [31:26], rs [25:21], rt [20:16], rd [15:11].
- instr_valid_i  in  1  IF/ID holds a real instruction.
- flush_i  in  1  branch taken, resolved in MEM.
- stall_o  out  1  combinational; freeze PC and IF/ID this cycle.
- illegal_o  out  1  registered; unknown opcode entered ID/EX.
- ex_alusrc_o  out  1  ID/EX ALUSrc.
- ex_aluop_o  out  ALUOP_W  ID/EX ALU_op.
- ex_regdst_o  out  2  ID/EX RegDst (0 = rt, 1 = rd).
- ex_wreg_o  out  REG_W  ID/EX destination register.
- mem_branch_o  out  1  EX/MEM Branch.
- mem_bne_o  out  1  EX/MEM branch type (1 = BNE, 0 = BEQ).
- mem_memread_o  out  1  EX/MEM MemRead.
- mem_memwrite_o  out  1  EX/MEM MemWrite.
- mem_wreg_o  out  REG_W  EX/MEM destination register.
- wb_regwrite_o  out  1  MEM/WB RegWrite.
- wb_memtoreg_o  out  2  MEM/WB MemtoReg (0 = ALU, 1 = memory).
- wb_wreg_o  out  REG_W  MEM/WB destination register.

Behaviour:
- Reset: all registered outputs and illegal_o go to 0 immediately on rst_i high. The pipeline holds bubbles until the first edge after release.
- Decode table, as (op: ALUSrc, ALU_op, RegDst, Branch, BNE, MemRead, MemWrite, RegWrite, MemtoReg):
  - R 0: 0, 2, 1, 0, 0, 0, 0, 1, 0.
  - ADDI 8: 1, 3, 0, 0, 0, 0, 0, 1, 0.
  - SLTIU 9: 1, 4, 0, 0, 0, 0, 0, 1, 0.
  - ORI 13: 1, 7, 0, 0, 0, 0, 0, 1, 0.
  - LUI 15 (new): 1, 5, 0, 0, 0, 0, 0, 1, 0.
  - BEQ 4: 0, 1, 0, 1, 0, 0, 0, 0, 0.
  - BNE 5: 0, 1, 0, 1, 1, 0, 0, 0, 0.
  - LW 35: 1, 3, 0, 0, 0, 1, 0, 1, 1.
  - SW 43: 1, 3, 0, 0, 0, 0, 1, 0, 0.
- Don't-care fields: every field is driven to a defined value; no field is left unassigned.
- Destination register: wreg = rd when RegDst = 1, else rt. Forced to 0 when RegWrite = 0.
- Bubble: all control fields 0 and wreg 0. A bubble never writes the register file or memory.
- Unknown opcode: decodes as a bubble; illegal_o = 1 for exactly the cycle that bubble occupies ID/EX.
- Latency: ID/EX fields valid 1 cycle after the IF/ID instruction is sampled. MEM fields follow at 2 cycles, WB fields at 3.
- Load-use hazard:
  - stall_o = HAZARD_EN & instr_valid_i & ID/EX MemRead & (ex_wreg_o != 0) & (ex_wreg_o == rs | ex_wreg_o == rt), all gated by !flush_i.
  - rt comparison applies only to R, BEQ, BNE and SW. rs comparison applies to all decoded opcodes.
  - During a stall, ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly one cycle per hazard.
- Flush:
  - ID/EX and EX/MEM load bubbles on the next edge. MEM/WB advances normally, so the branch itself retires.
  - Flush has priority over stall and over instr_valid_i.
- instr_valid_i = 0: ID/EX loads a bubble; stall_o = 0.
- Reset mid-operation: all stages clear asynchronously. No partial-state retention.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - opcode constants OP_R, OP_ADDI, OP_SLTIU, OP_BEQ, OP_BNE, OP_ORI, OP_LUI, OP_LW, OP_SW;
  - ALU_op constants ALUOP_BRANCH = 1, ALUOP_R = 2, ALUOP_ADDI = 3, ALUOP_SLTIU = 4, ALUOP_LUI = 5, ALUOP_ORI = 7;
  - packed control-word typedef and BUBBLE constant.
- Sub-module ctrl_decode_comb: pure combinational opcode → control word. The pipelined CPU also reuses it.
- The top holds the three stage registers and the hazard/flush logic.

Test Plan:
- Reset with rst_i high mid-stream while a LW sits in EX/MEM → all outputs 0 immediately. After release, the first ADDI $t1,$t0,5 yields ex_aluop_o = 3, ex_alusrc_o = 1, ex_wreg_o = 9 one edge later.
- R-type add $3,$1,$2 → cycle +1: ex_regdst_o = 1, ex_wreg_o = 3. Cycle +3: wb_regwrite_o = 1, wb_wreg_o = 3, wb_memtoreg_o = 0.
- LW $8,0($4) followed by add $9,$8,$1 → stall_o = 1 for one cycle; the next ID/EX is a bubble, then add proceeds. Repeat with HAZARD_EN = 0 → stall_o stays 0.
- LW $8 followed by ADDI $9,$0,1 (rt = 9, no use of $8) → no stall. LW $0 followed by add $9,$0,$0 → no stall.
- BNE in MEM with flush_i = 1 while a load-use hazard is present in ID → stall_o = 0.
  - Next edge: ID/EX and EX/MEM carry bubbles (mem_memwrite_o = 0, mem_branch_o = 0).
  - wb_* shows the BNE with regwrite 0.
- Opcode 63 → ID/EX bubble, illegal_o = 1 for one cycle, wb_regwrite_o = 0 two cycles later. LUI $5 → ex_aluop_o = 5.
